// File: rtl/nios2_fp_sysid_arb_pkg.sv
// Shared types and constants for the two-master sysid read arbiter.
// Holds the FSM state type, data width and default expected sysid words.
package nios2_fp_sysid_arb_pkg;

  localparam int DW = 32;

  localparam logic [DW-1:0] EXP_ID_DEF = 32'd0;
  localparam logic [DW-1:0] EXP_TS_DEF = 32'd1457881118;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage

// File: rtl/nios2_fp_sysid_arbiter_if.sv
// One master read port of the sysid arbiter (Avalon-style pipelined read).
// master: the requester side; slave: the arbiter side.
interface nios2_fp_sysid_arbiter_if;
  import nios2_fp_sysid_arb_pkg::*;

  logic          read;
  logic          address;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  modport master (
    output read,
    output address,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  read,
    input  address,
    output waitrequest,
    output readdata,
    output readdatavalid
  );

endinterface

// File: rtl/nios2_fp_sysid_rr_arb.sv
// Two-way round-robin grant with a last-grant pointer.
// After reset the pointer favours master 0.
module nios2_fp_sysid_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt
);

  logic last;

  // choose the requester not granted last time when both ask
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b11:   gnt = ~last;
      2'b10:   gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

  // remember who won the most recent accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (en) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/nios2_fp_sysid_arbiter.sv
// Arbitrates two read masters onto one combinational sysid slave.
// Define SYSID_ARB_CHECK_EN to compare captured words against EXP_*.
module nios2_fp_sysid_arbiter
  import nios2_fp_sysid_arb_pkg::*;
#(
  parameter logic [DW-1:0] EXP_ID        = EXP_ID_DEF,
  parameter logic [DW-1:0] EXP_TIMESTAMP = EXP_TS_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  nios2_fp_sysid_arbiter_if.slave m0,
  nios2_fp_sysid_arbiter_if.slave m1,
  output logic                    s_address,
  input  logic [DW-1:0]           s_readdata,
  output logic                    id_mismatch
);

  state_t        state;
  state_t        nxt;
  logic [1:0]    req;
  logic          accept;
  logic          gnt;
  logic          addr_q;
  logic          idx_q;
  logic [DW-1:0] data_q;
  logic          resp;

  assign req    = {m1.read, m0.read};
  assign accept = (state == IDLE) && (|req);
  assign resp   = (state == RESP);

  nios2_fp_sysid_rr_arb u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .en    (accept),
    .gnt   (gnt)
  );

  assign m0.waitrequest = m0.read & ~(accept & ~gnt);
  assign m1.waitrequest = m1.read & ~(accept & gnt);

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next-state: one accept, one capture cycle, one response cycle
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = CAPTURE;
      CAPTURE: nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // latch the winner's address and index, then the slave word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= 1'b0;
      idx_q  <= 1'b0;
      data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= gnt ? m1.address : m0.address;
        idx_q  <= gnt;
      end
      if (state == CAPTURE) begin
        data_q <= s_readdata;
      end
    end
  end

  assign s_address = (state == CAPTURE) & addr_q;

  assign m0.readdatavalid = resp & ~idx_q;
  assign m1.readdatavalid = resp & idx_q;
  assign m0.readdata = (resp & ~idx_q) ? data_q : '0;
  assign m1.readdata = (resp & idx_q) ? data_q : '0;

`ifdef SYSID_ARB_CHECK_EN
  logic [DW-1:0] exp_word;
  logic          mismatch_q;

  assign exp_word = addr_q ? EXP_TIMESTAMP : EXP_ID;

  // sticky flag: any captured word differing from its expected value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mismatch_q <= 1'b0;
    end else if ((state == CAPTURE) && (s_readdata != exp_word)) begin
      mismatch_q <= 1'b1;
    end
  end

  assign id_mismatch = mismatch_q;
`else
  // expected words are only consumed by the optional check
  logic unused_exp;
  assign unused_exp  = ^{EXP_ID, EXP_TIMESTAMP};
  assign id_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_fp_sysid_arbiter.sv
// Bench for nios2_fp_sysid_arbiter: directed cases then random traffic.
// A transaction-level model predicts grants, latency and data each cycle.
module tb_nios2_fp_sysid_arbiter;

  localparam logic [31:0] TS  = 32'd1457881118;
  localparam logic [31:0] IDW = 32'd0;
`ifdef SYSID_ARB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  nios2_fp_sysid_arbiter_if m0 ();
  nios2_fp_sysid_arbiter_if m1 ();
  nios2_fp_sysid_arbiter_if m0b ();
  nios2_fp_sysid_arbiter_if m1b ();

  logic        s_address, s_address_b;
  logic [31:0] s_readdata, s_readdata_b;
  logic        id_mismatch, id_mismatch_b;

  assign s_readdata   = s_address ? TS : IDW;
  assign s_readdata_b = s_address_b ? TS : IDW;

  assign m0b.read    = m0.read;
  assign m0b.address = m0.address;
  assign m1b.read    = m1.read;
  assign m1b.address = m1.address;

  nios2_fp_sysid_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0),
    .m1          (m1),
    .s_address   (s_address),
    .s_readdata  (s_readdata),
    .id_mismatch (id_mismatch)
  );

  nios2_fp_sysid_arbiter #(
    .EXP_TIMESTAMP (32'd1457881119)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .m0          (m0b),
    .m1          (m1b),
    .s_address   (s_address_b),
    .s_readdata  (s_readdata_b),
    .id_mismatch (id_mismatch_b)
  );

  int tests = 0;
  int fails = 0;

  // model state
  int cyc;
  int free_at;
  int acc_cyc;
  bit last;
  bit acc_m;
  bit acc_a;
  bit mm_b;
  bit got0, got1;

  // observations of the last tick
  logic        ow0, ow1, ov0, ov1;
  logic [31:0] ord0, ord1;

  task automatic chk1(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m0.read = 1'b0;
    m0.address = 1'b0;
    m1.read = 1'b0;
    m1.address = 1'b0;
    @(negedge clock);
    chk1("rst_v0", m0.readdatavalid, 1'b0);
    chk1("rst_v1", m1.readdatavalid, 1'b0);
    chk32("rst_rd0", m0.readdata, 32'd0);
    chk32("rst_rd1", m1.readdata, 32'd0);
    chk1("rst_saddr", s_address, 1'b0);
    chk1("rst_mm", id_mismatch, 1'b0);
    chk1("rst_mm_b", id_mismatch_b, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    free_at = 0;
    acc_cyc = -10;
    last = 1'b1;
    mm_b = 1'b0;
  endtask

  // one clock cycle: apply inputs, predict, compare at negedge
  task automatic tick(input logic r0, input logic a0,
                      input logic r1, input logic a1);
    bit acc, g, in_cap, in_resp;
    logic [31:0] dat;
    m0.read = r0;
    m0.address = a0;
    m1.read = r1;
    m1.address = a1;
    acc = 1'b0;
    g = 1'b0;
    if (cyc >= free_at && (r0 || r1)) begin
      acc = 1'b1;
      g = (r0 && r1) ? !last : r1;
      last = g;
      free_at = cyc + 3;
      acc_cyc = cyc;
      acc_m = g;
      acc_a = g ? a1 : a0;
    end
    in_cap = (cyc == acc_cyc + 1);
    in_resp = (cyc == acc_cyc + 2);
    dat = acc_a ? TS : IDW;
    @(negedge clock);
    ow0 = m0.waitrequest;
    ow1 = m1.waitrequest;
    ov0 = m0.readdatavalid;
    ov1 = m1.readdatavalid;
    ord0 = m0.readdata;
    ord1 = m1.readdata;
    chk1("m0_wait", ow0, r0 && !(acc && !g));
    chk1("m1_wait", ow1, r1 && !(acc && g));
    chk1("m0_valid", ov0, in_resp && !acc_m);
    chk1("m1_valid", ov1, in_resp && acc_m);
    chk32("m0_data", ord0, (in_resp && !acc_m) ? dat : 32'd0);
    chk32("m1_data", ord1, (in_resp && acc_m) ? dat : 32'd0);
    chk1("s_addr", s_address, in_cap ? acc_a : 1'b0);
    chk1("mismatch", id_mismatch, 1'b0);
    chk1("mismatch_b", id_mismatch_b, mm_b);
    if (CHK && in_cap && acc_a) mm_b = 1'b1;
    got0 = acc && !g;
    got1 = acc && g;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int n, nw;
    bit exp_g, obs_g;
    logic rr0, ra0, rr1, ra1;

    do_reset();

    // single master reads the timestamp
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk1("031_accept", ow0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("031_valid", ov0, 1'b1);
    chk32("031_data", ord0, TS);
    chk1("031_m1_valid", ov1, 1'b0);
    chk32("031_m1_data", ord1, 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("035_sticky", id_mismatch_b, CHK);

    // simultaneous requests straight out of reset
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    chk1("032_m0_first", ow0, 1'b0);
    chk1("032_m1_waits", ow1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk1("032_v0", ov0, 1'b1);
    chk32("032_d0", ord0, IDW);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk1("032_m1_accept", ow1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("032_v1", ov1, 1'b1);
    chk32("032_d1", ord1, TS);

    // continuous contention alternates grants
    do_reset();
    n = 0;
    exp_g = 1'b0;
    for (int i = 0; i < 30 && n < 6; i++) begin
      tick(1'b1, 1'($urandom_range(1, 0)), 1'b1, 1'($urandom_range(1, 0)));
      if (!ow0 || !ow1) begin
        obs_g = ow0;
        chk1("033_grant", obs_g, exp_g);
        exp_g = ~exp_g;
        n++;
      end
    end
    chk32("033_count", n, 32'd6);

    // held request during another master's transaction
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      if (!ow1) break;
      nw++;
    end
    chk32("036_wait_cycles", nw, 32'd2);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("036_valid", ov1, 1'b1);
    chk32("036_data", ord1, TS);

    // reset while in CAPTURE aborts the read
    do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk1("034_reissue", ow0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk1("034_valid", ov0, 1'b1);
    chk32("034_data", ord0, TS);

    // random traffic with occasional resets
    do_reset();
    rr0 = 1'b0;
    rr1 = 1'b0;
    ra0 = 1'b0;
    ra1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!rr0 && $urandom_range(1, 0) == 1) begin
        rr0 = 1'b1;
        ra0 = 1'($urandom_range(1, 0));
      end
      if (!rr1 && $urandom_range(1, 0) == 1) begin
        rr1 = 1'b1;
        ra1 = 1'($urandom_range(1, 0));
      end
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
        rr0 = 1'b0;
        rr1 = 1'b0;
      end else begin
        tick(rr0, ra0, rr1, ra1);
        if (got0) rr0 = 1'b0;
        if (got1) rr1 = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
